// File: rtl/pipeline_pkg.sv
// Shared pipeline constants for the fetch side of the pipeline.
// Holds the reset PC, the NOP encoding, the word width and the
// IF/ID hold-stage state encoding.
package pipeline_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000;
  // sll $0,$0,0
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef enum logic [1:0] {
    StRun   = ST_RUN,
    StHold  = ST_HOLD,
    StFlush = ST_FLUSH
  } hold_state_e;

endpackage

// File: rtl/stall_watchdog.sv
// Stall watchdog: counts consecutive hold cycles and flags a sticky timeout.
// Ports:
//   Clk      rising-edge clock
//   Reset    synchronous active-high reset
//   in_hold  1 = the stage is (entering or remaining) in HOLD this edge
//   clear    1 = zero the count this edge (wins over in_hold)
//   count    consecutive hold cycles, saturating at 255
//   timeout  sticky: count tried to go beyond MAX_STALL
module stall_watchdog
  import pipeline_pkg::*;
#(
  parameter int unsigned MAX_STALL = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       in_hold,
  input  logic       clear,
  output logic [7:0] count,
  output logic       timeout
);

  localparam logic [7:0] MaxStall = 8'(MAX_STALL);

  logic [7:0] count_q, count_d;
  logic       timeout_q, timeout_d;

  always_comb begin
    count_d   = count_q;
    timeout_d = timeout_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (in_hold) begin
      if (count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
      // The increment about to happen takes the count past the limit.
      if (count_q >= MaxStall) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q   <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign count   = count_q;
  assign timeout = timeout_q;

endmodule

// File: rtl/if_id_hold_stage.sv
// IF/ID hold stage: owns the PC and the IF/ID pipeline register and applies
// hold, flush and bubble requests from the hazard detector.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   PCWrite, IF_ID_Write       register write enables (0 = hold)
//   IF_Flush                   squash IF/ID to an invalid NOP
//   stall_ID_EX                request a bubble into ID/EX next cycle
//   PCNext, Instruction_in,
//   PCPlus4_in                 fetch-side data
//   PC                         current fetch address
//   IF_ID_Instruction/PCPlus4/
//   IF_ID_Valid                IF/ID register contents presented to ID
//   ID_EX_Bubble               registered zero-control strobe for ID/EX
//   StallCount, StallTimeout   hold statistics and sticky watchdog flag
module if_id_hold_stage #(
  parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR,
  parameter int unsigned MAX_STALL = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        IF_Flush,
  input  logic        stall_ID_EX,
  input  logic [31:0] PCNext,
  input  logic [31:0] Instruction_in,
  input  logic [31:0] PCPlus4_in,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        ID_EX_Bubble,
  output logic [7:0]  StallCount,
  output logic        StallTimeout
);

  import pipeline_pkg::*;

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pcp4_q, pcp4_d;
  logic              valid_q, valid_d;
  logic              bubble_q, bubble_d;
  hold_state_e       state_q, state_d;
  logic              both_held;

  assign both_held = !PCWrite && !IF_ID_Write && !IF_Flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHold: begin
        // Flush beats release.
        if (IF_Flush)       state_d = StFlush;
        else if (!both_held) state_d = StRun;
      end
      StRun, StFlush: begin
        if (IF_Flush)       state_d = StFlush;
        else if (both_held) state_d = StHold;
        else                state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    pc_d     = PCWrite ? PCNext : pc_q;
    instr_d  = instr_q;
    pcp4_d   = pcp4_q;
    valid_d  = valid_q;
    if (IF_Flush) begin
      instr_d = NOP_INSTR;
      pcp4_d  = '0;
      valid_d = 1'b0;
    end else if (IF_ID_Write) begin
      instr_d = Instruction_in;
      pcp4_d  = PCPlus4_in;
      valid_d = 1'b1;
    end
    // A flushed slot must never issue, so it also becomes a bubble.
    bubble_d = stall_ID_EX || IF_Flush;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pcp4_q   <= '0;
      valid_q  <= 1'b0;
      bubble_q <= 1'b0;
      state_q  <= StRun;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcp4_q   <= pcp4_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
      state_q  <= state_d;
    end
  end

  // Counting follows the state being entered, so the entry edge counts as 1
  // and the exit edge clears.
  stall_watchdog #(
    .MAX_STALL (MAX_STALL)
  ) u_stall_watchdog (
    .Clk     (Clk),
    .Reset   (Reset),
    .in_hold (state_d == StHold),
    .clear   (state_d != StHold),
    .count   (StallCount),
    .timeout (StallTimeout)
  );

  assign PC                = pc_q;
  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PCPlus4     = pcp4_q;
  assign IF_ID_Valid       = valid_q;
  assign ID_EX_Bubble      = bubble_q;

endmodule

// File: tb/tb_if_id_hold_stage.sv
// Directed bench for if_id_hold_stage with hand-computed expectations.
module tb_if_id_hold_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, if_id_write, if_flush, stall_id_ex;
  logic [31:0] pc_next, instr_in, pcp4_in;
  logic [31:0] pc, if_id_instr, if_id_pcp4;
  logic        if_id_valid, id_ex_bubble, stall_timeout;
  logic [7:0]  stall_count;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  if_id_hold_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000),
    .MAX_STALL (15)
  ) dut (
    .Clk               (clk),
    .Reset             (rst),
    .PCWrite           (pc_write),
    .IF_ID_Write       (if_id_write),
    .IF_Flush          (if_flush),
    .stall_ID_EX       (stall_id_ex),
    .PCNext            (pc_next),
    .Instruction_in    (instr_in),
    .PCPlus4_in        (pcp4_in),
    .PC                (pc),
    .IF_ID_Instruction (if_id_instr),
    .IF_ID_PCPlus4     (if_id_pcp4),
    .IF_ID_Valid       (if_id_valid),
    .ID_EX_Bubble      (id_ex_bubble),
    .StallCount        (stall_count),
    .StallTimeout      (stall_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle. Fetch data models a memory returning 0x8C080000 + addr,
  // addressed by the bench's own notion of the current PC.
  task automatic step(input logic r, input logic pcw, input logic ifw,
                      input logic fl, input logic st, input logic [31:0] cur_pc);
    rst         = r;
    pc_write    = pcw;
    if_id_write = ifw;
    if_flush    = fl;
    stall_id_ex = st;
    pc_next     = cur_pc + 32'd4;
    instr_in    = 32'h8C08_0000 + cur_pc;
    pcp4_in     = cur_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("rst_pc",      pc,            32'h0);
    check_eq("rst_instr",   if_id_instr,   32'h0);
    check_eq("rst_pcp4",    if_id_pcp4,    32'h0);
    check_eq("rst_valid",   {31'b0, if_id_valid},   32'd0);
    check_eq("rst_bubble",  {31'b0, id_ex_bubble},  32'd0);
    check_eq("rst_count",   {24'b0, stall_count},   32'd0);
    check_eq("rst_timeout", {31'b0, stall_timeout}, 32'd0);

    // Normal flow: PC 0 -> 4 -> 8 -> 12, IF/ID one fetch behind.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("run1_pc",    pc,          32'd4);
    check_eq("run1_instr", if_id_instr, 32'h8C08_0000);
    check_eq("run1_valid", {31'b0, if_id_valid}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd4);
    check_eq("run2_pc",    pc,          32'd8);
    check_eq("run2_instr", if_id_instr, 32'h8C08_0004);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd8);
    check_eq("run3_pc",    pc,          32'd12);
    check_eq("run3_instr", if_id_instr, 32'h8C08_0008);
    check_eq("run3_pcp4",  if_id_pcp4,  32'd12);

    // Load-use stall for one cycle.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd12);
    check_eq("lu_pc",     pc,          32'd12);
    check_eq("lu_instr",  if_id_instr, 32'h8C08_0008);
    check_eq("lu_bubble", {31'b0, id_ex_bubble}, 32'd1);
    check_eq("lu_count",  {24'b0, stall_count},  32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd12);
    check_eq("lu_rel_pc",     pc,          32'd16);
    check_eq("lu_rel_instr",  if_id_instr, 32'h8C08_000C);
    check_eq("lu_rel_bubble", {31'b0, id_ex_bubble}, 32'd0);
    check_eq("lu_rel_count",  {24'b0, stall_count},  32'd0);

    // Flush while holding the PC, IF_ID_Write asserted to show flush priority.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd16);
    check_eq("fl_pc",     pc,          32'd16);
    check_eq("fl_instr",  if_id_instr, 32'h0);
    check_eq("fl_pcp4",   if_id_pcp4,  32'h0);
    check_eq("fl_valid",  {31'b0, if_id_valid},  32'd0);
    check_eq("fl_bubble", {31'b0, id_ex_bubble}, 32'd1);
    check_eq("fl_count",  {24'b0, stall_count},  32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd16);
    check_eq("fl_rel_pc",     pc,          32'd20);
    check_eq("fl_rel_instr",  if_id_instr, 32'h8C08_0010);
    check_eq("fl_rel_bubble", {31'b0, id_ex_bubble}, 32'd0);

    // Mixed enables: PC advances, IF/ID holds, no stall counted.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd20);
    check_eq("mix_pc",    pc,          32'd24);
    check_eq("mix_instr", if_id_instr, 32'h8C08_0010);
    check_eq("mix_count", {24'b0, stall_count}, 32'd0);

    // Watchdog: 15 held cycles is still fine, the 16th trips it.
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd24);
    check_eq("wd15_count",   {24'b0, stall_count},   32'd15);
    check_eq("wd15_timeout", {31'b0, stall_timeout}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd24);
    check_eq("wd16_count",   {24'b0, stall_count},   32'd16);
    check_eq("wd16_timeout", {31'b0, stall_timeout}, 32'd1);
    check_eq("wd16_pc",      pc,                     32'd24);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd24);
    check_eq("wd_rel_count",   {24'b0, stall_count},   32'd0);
    check_eq("wd_rel_timeout", {31'b0, stall_timeout}, 32'd1);
    check_eq("wd_rel_pc",      pc,                     32'd28);

    // Saturation over 300 held cycles.
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd28);
    check_eq("sat_count", {24'b0, stall_count}, 32'd255);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd28);
    check_eq("sat_rel_count", {24'b0, stall_count}, 32'd0);

    // Reset mid-hold with a pending bubble request.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd32);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4);
    check_eq("mh_count",   {24'b0, stall_count},   32'd7);
    check_eq("mh_timeout", {31'b0, stall_timeout}, 32'd0);
    check_eq("mh_pc",      pc,                     32'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4);
    check_eq("mhr_pc",     pc,                     32'd0);
    check_eq("mhr_valid",  {31'b0, if_id_valid},   32'd0);
    check_eq("mhr_count",  {24'b0, stall_count},   32'd0);
    check_eq("mhr_bubble", {31'b0, id_ex_bubble},  32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_hold_stage.md
Name: if_id_hold_stage

Overview:
- Consumer end of the hazard-detection interface.
- Owns the PC register and the IF/ID pipeline register. Applies the hold (PCWrite/IF_ID_Write), flush (IF_Flush) and bubble (stall_ID_EX) requests from the hazard detector.
- Produces a registered bubble strobe for the ID/EX control mux, plus stall statistics and a stall watchdog.
- Sits between instruction memory/PC-adder and the ID stage.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000000, instruction word placed in IF/ID on flush or reset (sll $0,$0,0).
- MAX_STALL, 15, consecutive hold cycles tolerated before StallTimeout asserts; range 1..255.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- PCWrite  in  1  1 = PC loads PCNext this cycle
- IF_ID_Write  in  1  1 = IF/ID loads fetched instruction this cycle
- IF_Flush  in  1  1 = IF/ID loads NOP_INSTR, marked invalid
- stall_ID_EX  in  1  1 = request bubble into ID/EX next cycle
- PCNext  in  32  next PC (PC+4 or branch/jump target)
- Instruction_in  in  32  instruction memory data for current PC
- PCPlus4_in  in  32  PC+4 of current fetch
- PC  out  32  current fetch address
- IF_ID_Instruction  out  32  instruction presented to ID
- IF_ID_PCPlus4  out  32  PC+4 presented to ID
- IF_ID_Valid  out  1  1 = IF_ID_Instruction is a real fetched instruction
- ID_EX_Bubble  out  1  registered: 1 = ID/EX must latch zero control signals
- StallCount  out  8  consecutive cycles currently held, saturating at 255
- StallTimeout  out  1  sticky: hold exceeded MAX_STALL

Behaviour:
Clocking and reset:
- All state updates on the rising edge of Clk. Reset is synchronous, active-high, and highest priority.
- On reset: PC=RESET_PC, IF_ID_Instruction=NOP_INSTR, IF_ID_PCPlus4=0, IF_ID_Valid=0, ID_EX_Bubble=0, StallCount=0, StallTimeout=0, state=RUN.
- Reset asserted mid-stall or mid-flush abandons the operation fully. There is no carry-over of the count or the timeout.

PC register:
- PCWrite=1: load PCNext.
- PCWrite=0: hold.
- Independent of IF_Flush.

IF/ID register, priority IF_Flush > IF_ID_Write:
- IF_Flush=1: Instruction=NOP_INSTR, PCPlus4=0, Valid=0, regardless of IF_ID_Write.
- Else IF_ID_Write=1: load Instruction_in, PCPlus4_in, Valid=1.
- Else: hold all three, including Valid.

ID_EX_Bubble:
- Registers stall_ID_EX; one-cycle latency. Asserted the cycle after the request, for exactly as many cycles as stall_ID_EX was high.
- Forced to 1 the cycle after IF_Flush=1, so a flushed slot never issues.

State machine, evaluated each edge after reset:
- RUN: normal flow. Go to HOLD when PCWrite=0 and IF_ID_Write=0 and IF_Flush=0. Go to FLUSH when IF_Flush=1.
- HOLD: StallCount increments (saturating) every cycle in HOLD; entry cycle counts as 1. Return to RUN when either write enable returns to 1. Go to FLUSH on IF_Flush=1, which takes priority over release.
- FLUSH: one-cycle state; StallCount cleared. Next state is HOLD or RUN per the same inputs as RUN.
- Leaving HOLD clears StallCount to 0 on the exit edge.

Watchdog:
- StallTimeout sets on the edge where StallCount would exceed MAX_STALL.
- Stays set until Reset. The pipeline is not altered; it is a diagnostic only.

Mixed enables:
- PCWrite=1 with IF_ID_Write=0 (or the reverse) is legal. Each register obeys its own enable.
- State is RUN (not HOLD).

Decomposition:
- Shared package (pipeline_pkg): NOP_INSTR, RESET_PC, state encoding localparams (ST_RUN=2'd0, ST_HOLD=2'd1, ST_FLUSH=2'd2), and the 32-bit instruction/word width constant.
- One natural sub-module: stall_watchdog, holding the saturating 8-bit StallCount and the sticky StallTimeout. Inputs: Clk, Reset, in_hold, clear. Output: count and timeout.
- The PC and IF/ID registers stay in the top module.

Test Plan:
- Reset, then 3 cycles with PCWrite=IF_ID_Write=1, PCNext=PC+4, memory returning 0x8C080000 at PC 0 -> PC sequence 0,4,8,12. IF_ID_Instruction lags PC by one cycle. IF_ID_Valid=1 from the second cycle on.
- Load-use stall: one cycle with PCWrite=0, IF_ID_Write=0, stall_ID_EX=1 -> PC and IF/ID unchanged that edge. ID_EX_Bubble=1 for exactly the following cycle. StallCount=1, then returns to 0.
- Flush while holding: PCWrite=0, IF_ID_Write=0, IF_Flush=1 -> IF_ID_Instruction=0x00000000, Valid=0, PC held. ID_EX_Bubble=1 next cycle. State passes through FLUSH.
- Watchdog: hold for 16 consecutive cycles with MAX_STALL=15 -> StallCount reaches 16 and StallTimeout=1. After release, StallCount=0 and StallTimeout stays 1 until Reset.
- Saturation: hold 300 cycles -> StallCount stops at 255, no wrap.
- Reset mid-hold (StallCount=7, StallTimeout=0) -> next edge PC=RESET_PC, Valid=0, StallCount=0, ID_EX_Bubble=0.
